// File: rtl/decay_sched.sv
// decay_sched: neuron synaptic-current bank with a pipelined decay sweep.
//
// Holds N_NEURONS signed 17-bit currents. A tick starts a sweep that feeds
// the bank to an external decay datapath two neurons per cycle (even/odd
// pair) and writes the decayed results back LAT cycles later. Between
// sweeps the bank accepts saturating current injections.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tick                  request one decay sweep
//   decay_cfg             decay constant, captured when a sweep starts
//   inj_valid/inj_ready   injection handshake (ready only while idle)
//   inj_addr, inj_val     injection target and signed current to add
//   rd_addr, rd_data      combinational read port of the bank
//   dp_write              issue strobe to the decay datapath
//   dp_decay              latched decay constant during issue
//   dp_curr_in1/2         even/odd neuron currents during issue
//   dp_i_prime1/2         decayed even/odd results, LAT cycles after issue
//   busy                  sweep in progress
//   done                  one-cycle pulse after a sweep completes
//   overrun               one-cycle pulse when a tick is dropped
module decay_sched #(
  parameter int N_NEURONS = 16,
  parameter int AW        = 4,
  parameter int LAT       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [16:0]          decay_cfg,
  input  logic                 inj_valid,
  output logic                 inj_ready,
  input  logic [AW-1:0]        inj_addr,
  input  logic signed [16:0]   inj_val,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [16:0]   rd_data,
  output logic                 dp_write,
  output logic [16:0]          dp_decay,
  output logic signed [16:0]   dp_curr_in1,
  output logic signed [16:0]   dp_curr_in2,
  input  logic signed [16:0]   dp_i_prime1,
  input  logic signed [16:0]   dp_i_prime2,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int NPAIR = N_NEURONS / 2;
  localparam int PW    = AW - 1;
  localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [PW-1:0] PAIR_LAST  = PW'(NPAIR - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  // Signed add clamped to the 17-bit range [-65536, 65535].
  function automatic logic signed [16:0] sat_add(input logic signed [16:0] a,
                                                 input logic signed [16:0] b);
    logic signed [17:0] s;
    s = 18'({a[16], a}) + 18'({b[16], b});
    if (s > 18'sd65535)       return 17'h0FFFF;
    else if (s < -18'sd65536) return 17'h10000;
    else                      return s[16:0];
  endfunction

  state_t                state_q, state_d;
  logic [PW-1:0]         pair_q, pair_d;
  logic [CW-1:0]         drain_q, drain_d;
  logic [16:0]           decay_q, decay_d;
  logic                  pending_q, pending_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic signed [16:0]    bank_q [N_NEURONS];
  logic signed [16:0]    bank_d [N_NEURONS];
  logic [LAT-1:0]        wb_vld_q, wb_vld_d;
  logic [PW-1:0]         wb_idx_q [LAT];
  logic [PW-1:0]         wb_idx_d [LAT];
  logic                  issuing;

  assign issuing = (state_q == ISSUE);

  // Issue stage: control sequencing, injections and writebacks.
  // Injections only happen in IDLE and writebacks only while busy, so the
  // two bank write sources never collide.
  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    drain_d   = drain_q;
    decay_d   = decay_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    bank_d    = bank_q;

    case (state_q)
      IDLE: begin
        if (inj_valid) begin
          bank_d[inj_addr] = sat_add(bank_q[inj_addr], inj_val);
        end
        if (tick || pending_q) begin
          state_d   = ISSUE;
          pair_d    = '0;
          decay_d   = decay_cfg;
          pending_d = 1'b0;
        end
      end
      ISSUE: begin
        pair_d = pair_q + 1'b1;
        if (pair_q == PAIR_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only one sweep can be queued; a further tick is reported and dropped.
    if (state_q != IDLE && tick) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    if (wb_vld_q[LAT-1]) begin
      bank_d[{wb_idx_q[LAT-1], 1'b0}] = dp_i_prime1;
      bank_d[{wb_idx_q[LAT-1], 1'b1}] = dp_i_prime2;
    end
  end

  // Writeback tracking: the pair index follows the datapath latency.
  always_comb begin
    wb_vld_d    = '0;
    wb_vld_d[0] = issuing;
    wb_idx_d[0] = pair_q;
    for (int i = 1; i < LAT; i++) begin
      wb_vld_d[i] = wb_vld_q[i-1];
      wb_idx_d[i] = wb_idx_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pair_q    <= '0;
      drain_q   <= '0;
      decay_q   <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      wb_vld_q  <= '0;
      for (int i = 0; i < N_NEURONS; i++) bank_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pair_q    <= pair_d;
      drain_q   <= drain_d;
      decay_q   <= decay_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      wb_vld_q  <= wb_vld_d;
      for (int i = 0; i < N_NEURONS; i++) bank_q[i] <= bank_d[i];
    end
  end

  // Pair indices are qualified by wb_vld_q, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LAT; i++) wb_idx_q[i] <= wb_idx_d[i];
  end

  // Output stage: datapath operands are forced to zero outside ISSUE.
  assign inj_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign overrun     = overrun_q;
  assign dp_write    = issuing;
  assign dp_decay    = issuing ? decay_q : '0;
  assign dp_curr_in1 = issuing ? bank_q[{pair_q, 1'b0}] : '0;
  assign dp_curr_in2 = issuing ? bank_q[{pair_q, 1'b1}] : '0;
  assign rd_data     = bank_q[rd_addr];

endmodule

// File: tb/tb_decay_sched.sv
// Testbench for decay_sched (N_NEURONS=16, LAT=1) with a datapath model
// i_prime = i >>> 1. Expected issue operands go into a queue; a monitor
// pops and compares them whenever dp_write is seen.
module tb_decay_sched;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               tick = 1'b0;
  logic [16:0]        decay_cfg = '0;
  logic               inj_valid = 1'b0;
  logic               inj_ready;
  logic [3:0]         inj_addr = '0;
  logic signed [16:0] inj_val = '0;
  logic [3:0]         rd_addr = '0;
  logic signed [16:0] rd_data;
  logic               dp_write;
  logic [16:0]        dp_decay;
  logic signed [16:0] dp_curr_in1, dp_curr_in2;
  logic signed [16:0] p1_q = '0, p2_q = '0;
  logic               busy, done, overrun;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [16:0] c1;
    logic [16:0] c2;
    logic [16:0] dc;
  } iss_t;
  iss_t exp_q[$];
  logic signed [16:0] exp_bank [16];

  decay_sched #(.N_NEURONS(16), .AW(4), .LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .decay_cfg(decay_cfg),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_addr(inj_addr),
    .inj_val(inj_val), .rd_addr(rd_addr), .rd_data(rd_data),
    .dp_write(dp_write), .dp_decay(dp_decay),
    .dp_curr_in1(dp_curr_in1), .dp_curr_in2(dp_curr_in2),
    .dp_i_prime1(p1_q), .dp_i_prime2(p2_q),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Decay datapath model, one cycle of latency.
  always @(posedge clk) begin
    if (dp_write) begin
      p1_q <= dp_curr_in1 >>> 1;
      p2_q <= dp_curr_in2 >>> 1;
    end
  end

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every issued pair is compared against the next expected entry.
  always @(negedge clk) begin
    iss_t e;
    if (rst_n && dp_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got curr1=%h curr2=%h expected no issue",
                 dp_curr_in1, dp_curr_in2);
      end else begin
        e = exp_q.pop_front();
        chk("issue_curr1", dp_curr_in1, e.c1);
        chk("issue_curr2", dp_curr_in2, e.c2);
        chk("issue_decay", dp_decay, e.dc);
      end
    end
  end

  // Queue the first npairs operand pairs of a sweep, then age the model.
  task automatic push_sweep(input logic [16:0] dc, input int npairs);
    for (int k = 0; k < npairs; k++)
      exp_q.push_back('{c1: exp_bank[2*k], c2: exp_bank[2*k+1], dc: dc});
    for (int i = 0; i < 16; i++) exp_bank[i] = exp_bank[i] >>> 1;
  endtask

  // Called and returns at posedge+1.
  task automatic inject(input logic [3:0] a, input logic [16:0] v);
    inj_addr  = a;
    inj_val   = v;
    inj_valid = 1'b1;
    @(posedge clk); #1;
    inj_valid = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [3:0] a, input logic [16:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(name, rd_data, exp);
    @(posedge clk); #1;
  endtask

  // Cycle 0 carries the tick; extra ticks at cycles ta/tb; inj_valid raised at
  // cycle inj_from and dropped after the edge where it was accepted.
  task automatic run_sweep(input int ta, input int tb, input int inj_from, input int n_done,
                           output int d1, output int d2, output int wr, output int ov,
                           output int stall, output int acc_at);
    int  ndone;
    bit  acc;
    d1 = -1; d2 = -1; wr = 0; ov = 0; stall = 0; acc_at = -1; ndone = 0;
    for (int i = 0; i < 60; i++) begin
      tick = (i == 0 || i == ta || i == tb);
      if (i == inj_from) inj_valid = 1'b1;
      @(negedge clk);
      acc = inj_valid && inj_ready;
      if (acc) acc_at = i;
      if (busy && inj_ready) stall++;
      if (dp_write) wr++;
      if (overrun) ov++;
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = i; else d2 = i;
      end
      @(posedge clk); #1;
      if (acc) inj_valid = 1'b0;
      if (ndone == n_done) break;
    end
    tick = 1'b0;
  endtask

  initial begin
    int d1, d2, wr, ov, stall, acc_at, cnt_done, cnt_wr;
    for (int i = 0; i < 16; i++) exp_bank[i] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {16'b0, busy}, 17'h0);
    chk("rst_done", {16'b0, done}, 17'h0);
    chk("rst_overrun", {16'b0, overrun}, 17'h0);
    chk("rst_dp_write", {16'b0, dp_write}, 17'h0);
    chk("rst_inj_ready", {16'b0, inj_ready}, 17'h1);
    chk("rst_rd_data", rd_data, 17'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic sweep: two injected neurons halve, done 10 cycles after tick edge.
    inject(4'd0, 17'h08000);
    inject(4'd1, 17'h08000);
    exp_bank[0] = 17'h08000; exp_bank[1] = 17'h08000;
    decay_cfg = 17'h00123;
    push_sweep(decay_cfg, 8);
    run_sweep(-1, -1, -1, 1, d1, d2, wr, ov, stall, acc_at);
    chk_int("t1_writes", wr, 8);
    chk_int("t1_done_cycle", d1, 10);
    chk_int("t1_overrun", ov, 0);
    read_chk("t1_bank0", 4'd0, 17'h04000);
    read_chk("t1_bank1", 4'd1, 17'h04000);
    read_chk("t1_bank2", 4'd2, 17'h00000);

    // Saturating injections.
    inject(4'd3, 17'h0F000);
    inject(4'd3, 17'h0F000);
    inject(4'd4, 17'h10000);
    inject(4'd4, 17'h10000);
    inject(4'd5, 17'h00005);
    inject(4'd5, 17'h1FFFD);
    exp_bank[3] = 17'h0FFFF; exp_bank[4] = 17'h10000; exp_bank[5] = 17'h00002;
    read_chk("t2_sat_pos", 4'd3, 17'h0FFFF);
    read_chk("t2_sat_neg", 4'd4, 17'h10000);
    read_chk("t2_plain_sum", 4'd5, 17'h00002);

    // Injection held across a sweep is stalled until the idle done cycle.
    inj_addr = 4'd6; inj_val = 17'h00007;
    decay_cfg = 17'h1F00F;
    push_sweep(decay_cfg, 8);
    run_sweep(-1, -1, 1, 1, d1, d2, wr, ov, stall, acc_at);
    exp_bank[6] = 17'h00007;
    chk_int("t3_done_cycle", d1, 10);
    chk_int("t3_ready_while_busy", stall, 0);
    chk_int("t3_accept_cycle", acc_at, 10);
    read_chk("t3_bank6", 4'd6, 17'h00007);
    read_chk("t3_bank3", 4'd3, 17'h07FFF);
    read_chk("t3_bank4", 4'd4, 17'h18000);

    // Two ticks during a sweep: one queued, one dropped.
    inject(4'd0, 17'h06000);
    exp_bank[0] = 17'h08000;
    decay_cfg = 17'h00042;
    push_sweep(decay_cfg, 8);
    push_sweep(decay_cfg, 8);
    run_sweep(2, 4, -1, 2, d1, d2, wr, ov, stall, acc_at);
    chk_int("t4_overrun", ov, 1);
    chk_int("t4_done1", d1, 10);
    chk_int("t4_done2", d2, 20);
    chk_int("t4_writes", wr, 16);
    read_chk("t4_bank0", 4'd0, 17'h02000);
    read_chk("t4_bank4", 4'd4, 17'h1E000);
    read_chk("t4_bank6", 4'd6, 17'h00001);

    // Tick and injection on the same idle edge.
    inj_addr = 4'd2; inj_val = 17'h00100;
    exp_bank[2] = 17'h00100;
    decay_cfg = 17'h0ABCD;
    push_sweep(decay_cfg, 8);
    run_sweep(-1, -1, 0, 1, d1, d2, wr, ov, stall, acc_at);
    chk_int("t5_accept_cycle", acc_at, 0);
    chk_int("t5_done_cycle", d1, 10);
    read_chk("t5_bank2", 4'd2, 17'h00080);

    // Reset during pair 3 aborts the sweep.
    decay_cfg = 17'h00777;
    push_sweep(decay_cfg, 4);
    for (int i = 0; i < 5; i++) begin
      tick = (i == 0);
      @(negedge clk);
      if (i == 4) break;
      @(posedge clk); #1;
    end
    #1;
    rst_n = 1'b0;
    tick  = 1'b0;
    #1;
    chk_int("t6_pairs_seen", exp_q.size(), 0);
    chk("t6_busy", {16'b0, busy}, 17'h0);
    chk("t6_dp_write", {16'b0, dp_write}, 17'h0);
    chk("t6_dp_curr1", dp_curr_in1, 17'h0);
    chk("t6_dp_decay", dp_decay, 17'h0);
    chk("t6_inj_ready", {16'b0, inj_ready}, 17'h1);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) read_chk("t6_bank_reset", 4'(i), 17'h0);
    for (int i = 0; i < 16; i++) exp_bank[i] = '0;
    rst_n = 1'b1;
    cnt_done = 0; cnt_wr = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) cnt_done++;
      if (dp_write) cnt_wr++;
    end
    @(posedge clk); #1;
    chk_int("t6_no_done", cnt_done, 0);
    chk_int("t6_no_issue", cnt_wr, 0);

    // First tick after reset release is honoured.
    decay_cfg = 17'h00055;
    push_sweep(decay_cfg, 8);
    run_sweep(-1, -1, -1, 1, d1, d2, wr, ov, stall, acc_at);
    chk_int("t7_done_cycle", d1, 10);
    chk_int("t7_writes", wr, 8);

    repeat (2) @(posedge clk);
    chk_int("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
